// File: rtl/uart_tx_ctrl.sv
// UART transmitter control: latches a byte, sequences start/data/parity/stop, one clock per bit.
// Optional macro UART_TX_B2B_EN lets a new frame be accepted in STOP with no idle gap.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  ser_data,
  output logic [1:0]            mux_sel,
  output logic                  par_bit,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  par_bit_q, par_bit_d;
  logic                  par_en_q, par_en_d;
  logic                  accept;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    par_bit_d = par_bit_q;
    par_en_d  = par_en_q;
    accept    = 1'b0;
    case (state_q)
      S_IDLE:  accept = DATA_VALID;
      S_START: begin
        state_d = S_DATA;
        cnt_d   = '0;
      end
      S_DATA: begin
        shift_d = shift_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) state_d = par_en_q ? S_PARITY : S_STOP;
      end
      S_PARITY: state_d = S_STOP;
      S_STOP: begin
        state_d = S_IDLE;
`ifdef UART_TX_B2B_EN
        accept  = DATA_VALID;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    // Acceptance overrides the per-state update; PAR_TYP only matters here.
    if (accept) begin
      state_d   = S_START;
      shift_d   = P_DATA;
      par_en_d  = PAR_EN;
      par_bit_d = (^P_DATA) ^ PAR_TYP;
    end
  end

  always_comb begin
    mux_sel = 2'd1;
    case (state_q)
      S_START:  mux_sel = 2'd0;
      S_DATA:   mux_sel = 2'd2;
      S_PARITY: mux_sel = 2'd3;
      default:  mux_sel = 2'd1;
    endcase
    busy     = (state_q != S_IDLE);
    ser_data = shift_q[0];
    par_bit  = par_bit_q;
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed scenarios plus randomized frames
// checked against a per-cycle frame model derived from the frame format.
module tb_uart_tx_ctrl;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] P_DATA;
  logic         DATA_VALID;
  logic         PAR_EN;
  logic         PAR_TYP;
  logic         ser_data;
  logic [1:0]   mux_sel;
  logic         par_bit;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .ser_data  (ser_data),
    .mux_sel   (mux_sel),
    .par_bit   (par_bit),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Parity from the count of ones: even parity bit is 1 when the count is odd.
  function automatic logic model_par(input logic [W-1:0] d, input logic pt);
    int ones = 0;
    for (int i = 0; i < W; i++) ones += int'(d[i]);
    return ((ones % 2) == 1) ^ pt;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_mux"}, 32'(mux_sel), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Drive a one-cycle strobe at a falling edge; returns in the START cycle.
  task automatic start_frame(input logic [W-1:0] d, input logic pe, input logic pt);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
  endtask

  // Called in the START cycle; returns in the cycle after STOP.
  task automatic check_frame(input logic [W-1:0] d, input logic pe, input logic pt,
                             input logic noise);
    int   n       = W + 2 + int'(pe);
    logic exp_par = model_par(d, pt);
    for (int c = 0; c < n; c++) begin
      logic [1:0] exp_mux;
      if (c == 0)                 exp_mux = 2'd0;
      else if (c <= W)            exp_mux = 2'd2;
      else if (pe && c == W + 1)  exp_mux = 2'd3;
      else                        exp_mux = 2'd1;
      check($sformatf("mux_sel[c%0d]", c), 32'(mux_sel), 32'(exp_mux));
      check($sformatf("busy[c%0d]", c), 32'(busy), 32'd1);
      check($sformatf("par_bit[c%0d]", c), 32'(par_bit), 32'(exp_par));
      if (c == 0)       check("ser_data[start]", 32'(ser_data), 32'(d[0]));
      else if (c <= W)  check($sformatf("ser_data[bit%0d]", c - 1), 32'(ser_data), 32'(d[c-1]));
      if (noise && c >= 1 && c < W) begin
        P_DATA     = (c == 1) ? 8'hFF : 8'($urandom);
        DATA_VALID = 1'(c % 2);
        PAR_EN     = ~pe;
        PAR_TYP    = ~pt;
      end else if (noise && c == W) begin
        DATA_VALID = 1'b0;
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] rd;
    logic         rpe, rpt, rnoise;

    // Reset held with DATA_VALID asserted.
    RST = 1'b1; DATA_VALID = 1'b1; P_DATA = 8'h5A; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check_idle($sformatf("rst%0d", i));
      check("rst_ser", 32'(ser_data), 32'd0);
      check("rst_par", 32'(par_bit), 32'd0);
    end
    RST = 1'b0; DATA_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check_idle($sformatf("post_rst%0d", i));
    end

    // Even parity, 0xA5.
    start_frame(8'hA5, 1'b1, 1'b0);
    check_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    check_idle("a5_end");

    // No parity, 0x01.
    start_frame(8'h01, 1'b0, 1'b1);
    check_frame(8'h01, 1'b0, 1'b1, 1'b0);
    check_idle("01_end");

    // Odd parity with mid-frame input noise, 0x07.
    start_frame(8'h07, 1'b1, 1'b1);
    check_frame(8'h07, 1'b1, 1'b1, 1'b1);
    check_idle("07_end");
    @(negedge CLK);
    check_idle("07_no_retrigger");

    // Back-to-back with DATA_VALID held.
    P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b1; DATA_VALID = 1'b1;
    @(negedge CLK);
    P_DATA = 8'hC3;
    check_frame(8'h3C, 1'b1, 1'b1, 1'b0);
`ifndef UART_TX_B2B_EN
    check_idle("b2b_gap");
    @(negedge CLK);
`endif
    DATA_VALID = 1'b0;
    check_frame(8'hC3, 1'b1, 1'b1, 1'b0);
    check_idle("b2b_end");

    // Reset during data bit 4 of 0xFF.
    start_frame(8'hFF, 1'b1, 1'b0);
    repeat (5) @(negedge CLK);
    check("mid_bit4_mux", 32'(mux_sel), 32'd2);
    check("mid_bit4_ser", 32'(ser_data), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_idle("mid_rst");
    check("mid_rst_ser", 32'(ser_data), 32'd0);
    check("mid_rst_par", 32'(par_bit), 32'd0);
    @(negedge CLK);
    check_idle("mid_rst_after");
    start_frame(8'h96, 1'b1, 1'b1);
    check_frame(8'h96, 1'b1, 1'b1, 1'b0);
    check_idle("mid_rst_recover");

    // Randomized frames with random idle gaps.
    for (int f = 0; f < 24; f++) begin
      rd     = 8'($urandom);
      rpe    = 1'($urandom);
      rpt    = 1'($urandom);
      rnoise = 1'($urandom);
      repeat ($urandom_range(0, 2)) begin
        @(negedge CLK);
        check_idle("rnd_gap");
      end
      start_frame(rd, rpe, rpt);
      check_frame(rd, rpe, rpt, rnoise);
      check_idle("rnd_end");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
